// File: rtl/id_control_decoder_if.sv
// ID-stage control bus: opcode in, control bundle and sticky halt out.
// The decoder takes the slave modport; the stage feeding it takes master.
interface id_control_decoder_if;
  logic [3:0]  Opcode;
  logic [12:0] Control_Signals;
  logic        Halted;

  modport master (
    output Opcode,
    input  Control_Signals,
    input  Halted
  );

  modport slave (
    input  Opcode,
    output Control_Signals,
    output Halted
  );
endinterface

// File: rtl/id_control_decoder.sv
// ID-stage control decoder with a sticky halt flag.
// Define CONTROL_LOGIC_OUTREG_EN to register Control_Signals (one-cycle latency).
module id_control_decoder (
  input  logic                        Clk,
  input  logic                        Rst_n,
  id_control_decoder_if.slave         bus
);

  localparam logic [3:0]  OP_HALT   = 4'h0;
  localparam logic [12:0] CTRL_HALT = 13'h1000;

  logic [12:0] dec;
  logic [12:0] frozen;
  logic        halted;

  always_comb begin
    dec = 13'h0000;
    unique case (bus.Opcode)
      4'h0: dec = 13'h1000;
      4'h1: dec = 13'h0800;
      4'h2: dec = 13'h0810;
      4'h3: dec = 13'h0820;
      4'h4: dec = 13'h0830;
      4'h5: dec = 13'h0840;
      4'h6: dec = 13'h08D0;
      4'h7: dec = 13'h08E0;
      4'h8: dec = 13'h0880;
      4'h9: dec = 13'h0E80;
      4'hA: dec = 13'h0180;
      4'hB: dec = 13'h001C;
      4'hC: dec = 13'h0018;
      4'hD: dec = 13'h0802;
      4'hE: dec = 13'h0001;
      4'hF: dec = 13'h0003;
    endcase
  end

  // Once halted, nothing but the HALT pattern leaves this stage.
  assign frozen = halted ? CTRL_HALT : dec;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      halted <= 1'b0;
    end else if (bus.Opcode == OP_HALT) begin
      halted <= 1'b1;
    end
  end

`ifdef CONTROL_LOGIC_OUTREG_EN
  logic [12:0] ctrl_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl_q <= 13'h0000;
    end else begin
      ctrl_q <= frozen;
    end
  end

  assign bus.Control_Signals = ctrl_q;
`else
  assign bus.Control_Signals = frozen;
`endif

  assign bus.Halted = halted;

endmodule

// File: tb/tb_id_control_decoder.sv
// Bench for id_control_decoder: spec table sweep, halt/reset sequences,
// and random opcodes against a field-level reference model.
module tb_id_control_decoder;

  logic Clk;
  logic Rst_n;

  id_control_decoder_if bus ();

  id_control_decoder dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [3:0]  op;
    logic [12:0] exp;
  } vec_t;

  vec_t vt [16];

  // Reference decode built from instruction semantics, field by field.
  function automatic logic [12:0] ref_dec(input logic [3:0] op);
    int o;
    logic       halt, rw, m2r, mr, mw, src, br, bne;
    logic [2:0] alu;
    logic [1:0] js;
    o    = int'(op);
    halt = (o == 0);
    rw   = (o >= 1 && o <= 9) || o == 13;
    m2r  = (o == 9);
    mr   = (o == 9);
    mw   = (o == 10);
    src  = (o >= 6 && o <= 10);
    if (o >= 1 && o <= 7)       alu = 3'(o - 1);
    else if (o == 11 || o == 12) alu = 3'd1;
    else                        alu = 3'd0;
    br   = (o == 11 || o == 12);
    bne  = (o == 11);
    js   = (o == 13) ? 2'b10 : (o == 14) ? 2'b01 :
           (o == 15) ? 2'b11 : 2'b00;
    return {halt, rw, m2r, mr, mw, src, alu, br, bne, js};
  endfunction

  task automatic chk(input string nm, input logic [12:0] act,
                     input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  // Drive op between edges; check output after the path latency.
  task automatic apply(input logic [3:0] op, input logic [12:0] exp,
                       input string nm);
    @(negedge Clk);
    bus.Opcode = op;
`ifdef CONTROL_LOGIC_OUTREG_EN
    @(posedge Clk);
`endif
    #1;
    chk(nm, bus.Control_Signals, exp);
  endtask

  logic        halted_m;
  logic [12:0] reg_m;
  logic [12:0] exp_nxt;
  logic [3:0]  rop;

  initial begin
    n_vec = 0;
    n_bad = 0;
    vt[0]  = '{4'h1, 13'h0800};
    vt[1]  = '{4'h2, 13'h0810};
    vt[2]  = '{4'h3, 13'h0820};
    vt[3]  = '{4'h4, 13'h0830};
    vt[4]  = '{4'h5, 13'h0840};
    vt[5]  = '{4'h6, 13'h08D0};
    vt[6]  = '{4'h7, 13'h08E0};
    vt[7]  = '{4'h8, 13'h0880};
    vt[8]  = '{4'h9, 13'h0E80};
    vt[9]  = '{4'hA, 13'h0180};
    vt[10] = '{4'hB, 13'h001C};
    vt[11] = '{4'hC, 13'h0018};
    vt[12] = '{4'hD, 13'h0802};
    vt[13] = '{4'hE, 13'h0001};
    vt[14] = '{4'hF, 13'h0003};
    vt[15] = '{4'h0, 13'h1000};

    // Reset state
    Rst_n = 1'b0;
    bus.Opcode = 4'h2;
    #1;
    chk1("reset_halted", bus.Halted, 1'b0);
`ifdef CONTROL_LOGIC_OUTREG_EN
    chk("reset_out", bus.Control_Signals, 13'h0000);
`else
    chk("reset_out", bus.Control_Signals, 13'h0810);
`endif
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Opcode sweep, HALT last
    foreach (vt[i]) begin
      apply(vt[i].op, vt[i].exp, $sformatf("sweep_op%h", vt[i].op));
      chk("sweep_model", vt[i].exp, ref_dec(vt[i].op));
    end

    // HALT seen at an edge: sticky, output frozen
    @(posedge Clk);
    #1;
    chk1("halt_set", bus.Halted, 1'b1);
    apply(4'h1, 13'h1000, "halt_freeze_add");
    apply(4'hD, 13'h1000, "halt_freeze_jl");
    chk1("halt_sticky", bus.Halted, 1'b1);

    // Async reset mid-halt, no clock edge
    @(negedge Clk);
    bus.Opcode = 4'hA;
    #2;
    Rst_n = 1'b0;
    #1;
    chk1("rst_mid_halt", bus.Halted, 1'b0);
`ifdef CONTROL_LOGIC_OUTREG_EN
    chk("rst_mid_out", bus.Control_Signals, 13'h0000);
`else
    chk("rst_mid_out", bus.Control_Signals, 13'h0180);
`endif
    #1;
    Rst_n = 1'b1;
    apply(4'hA, 13'h0180, "after_rst_sw");

`ifdef CONTROL_LOGIC_OUTREG_EN
    // One-cycle latency: old value holds until the edge
    @(negedge Clk);
    bus.Opcode = 4'h2;
    #1;
    chk("outreg_hold", bus.Control_Signals, 13'h0180);
    @(posedge Clk);
    #1;
    chk("outreg_lat", bus.Control_Signals, 13'h0810);
`endif

    // Random opcodes with occasional resets
    halted_m = 1'b0;
    Rst_n    = 1'b0;
    #1;
    Rst_n    = 1'b1;
    reg_m    = 13'h0000;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if ($urandom_range(0, 39) == 0) begin
        Rst_n    = 1'b0;
        halted_m = 1'b0;
        reg_m    = 13'h0000;
        #1;
        chk1("rand_rst", bus.Halted, 1'b0);
        Rst_n = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) rop = 4'h0;
      else rop = 4'($urandom_range(1, 15));
      bus.Opcode = rop;
      exp_nxt = halted_m ? 13'h1000 : ref_dec(rop);
`ifndef CONTROL_LOGIC_OUTREG_EN
      #1;
      chk($sformatf("rand%0d_op%h", i, rop), bus.Control_Signals, exp_nxt);
      chk1($sformatf("rand%0d_halted", i), bus.Halted, halted_m);
`endif
      @(posedge Clk);
      halted_m = halted_m || (rop == 4'h0);
      reg_m    = exp_nxt;
`ifdef CONTROL_LOGIC_OUTREG_EN
      #1;
      chk($sformatf("rand%0d_op%h", i, rop), bus.Control_Signals, reg_m);
      chk1($sformatf("rand%0d_halted", i), bus.Halted, halted_m);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
